// File: rtl/display_scan_controller.sv
// Seven-segment scan sequencer: binary load, double-dabble BCD
// conversion, double-buffered display, time-multiplexed digit scan.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   bin_in    binary value, captured when load is accepted
//   load      conversion request, accepted only while busy=0
//   blank_lz  1 = blank leading zeros (digit 0 never blanked)
//   busy      conversion in progress
//   overflow  last accepted value exceeded 10^DIGITS-1
//   bcd_out   nibble of the scanned digit, 4'hF = blank
//   anode_n   active-low one-hot digit enable
module display_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  input  logic              blank_lz,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] anode_n
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_val(input int d);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < d; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [ACC_W-1:0]   r_disp;

  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;

  logic [ACC_W-1:0]   w_adj;
  logic [63:0]        w_bin_wide;
  logic               w_too_big;
  logic               w_tick;
  logic [IDX_W-1:0]   w_next_idx;
  logic [3:0]         w_digit;
  logic               w_upper_nz;
  logic               w_blank;

  assign w_bin_wide = 64'(bin_in);
  assign w_too_big  = w_bin_wide > MAX_VAL;

  // Add-3 correction on every nibble before the shift.
  // Carries out of the top digit are dropped; saturation
  // covers every input that could produce one.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end else begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_disp   <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= bin_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= w_too_big;
            busy    <= 1'b1;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_acc   <= {w_adj[ACC_W-2:0], r_shift[BIN_W-1]};
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_disp   <= r_sat ? {DIGITS{4'h9}} : r_acc;
          overflow <= r_sat;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_tick = (r_pre == PRE_W'(REFRESH_DIV - 1));

  assign w_next_idx = (r_idx == IDX_W'(DIGITS - 1))
                    ? '0
                    : r_idx + IDX_W'(1);

  assign w_digit = r_disp[{w_next_idx, 2'b00} +: 4];

  // Any nonzero digit at or above the next index
  // keeps that digit visible.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (d >= int'(w_next_idx) &&
          r_disp[4*d +: 4] != 4'h0) begin
        w_upper_nz = 1'b1;
      end
    end
  end

  assign w_blank = blank_lz &&
                   (w_next_idx != '0) &&
                   !w_upper_nz;

  // Scan runs free of the converter; outputs load
  // together with the index so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_idx   <= '0;
      anode_n <= ~DIGITS'(1);
      bcd_out <= 4'h0;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_idx   <= w_next_idx;
      anode_n <= ~(DIGITS'(1) << w_next_idx);
      bcd_out <= w_blank ? 4'hF : w_digit;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: decimal-arithmetic model
// checked every cycle, plus literal digit and timing checks.
module tb_display_scan_controller;

  localparam int D = 4;
  localparam int W = 14;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] bin_in;
  logic         load;
  logic         blank_lz;
  logic         busy;
  logic         overflow;
  logic [3:0]   bcd_out;
  logic [D-1:0] anode_n;

  display_scan_controller #(
    .DIGITS(D),
    .BIN_W(W),
    .REFRESH_DIV(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bin_in(bin_in),
    .load(load),
    .blank_lz(blank_lz),
    .busy(busy),
    .overflow(overflow),
    .bcd_out(bcd_out),
    .anode_n(anode_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int v;
    v = 1;
    for (int i = 0; i < e; i++) v = v * 10;
    return v;
  endfunction

  // Model: time counted in cycles, values kept as decimals.
  int         m_p;
  int         m_idx;
  int         m_left;
  int         m_pend;
  int         m_disp;
  bit         m_ovf;
  logic [3:0] m_bcd;

  always @(posedge clk) begin
    if (reset) begin
      m_p    = 0;
      m_idx  = 0;
      m_left = 0;
      m_disp = 0;
      m_ovf  = 1'b0;
      m_bcd  = 4'h0;
    end else begin
      if (m_p == R - 1) begin
        m_p   = 0;
        m_idx = (m_idx + 1) % D;
        if (blank_lz && m_idx > 0 &&
            m_disp / pow10(m_idx) == 0)
          m_bcd = 4'hF;
        else
          m_bcd = 4'((m_disp / pow10(m_idx)) % 10);
      end else begin
        m_p++;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ovf  = m_pend > pow10(D) - 1;
          m_disp = m_ovf ? pow10(D) - 1 : m_pend;
        end
      end else if (load) begin
        m_pend = int'(bin_in);
        m_left = W + 1;
      end
    end
  end

  logic [D-1:0] exp_an;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_an = ~(D'(1) << m_idx);
      chk("busy", busy, m_left > 0);
      chk("overflow", overflow, m_ovf);
      chk("anode_n", anode_n, exp_an);
      chk("bcd_out", bcd_out, m_bcd);
    end
  end

  task automatic do_load(input int v);
    load   = 1'b1;
    bin_in = W'(v);
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", busy, 1'b0);
  endtask

  task automatic scan_read(output logic [4*D-1:0] got);
    repeat (2 * D * R) @(negedge clk);
    got = '0;
    repeat (D * R) begin
      @(negedge clk);
      for (int j = 0; j < D; j++)
        if (anode_n[j] == 1'b0) got[4*j +: 4] = bcd_out;
    end
  endtask

  logic [4*D-1:0] dig;
  int             cnt;

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    chk("rst_anode", anode_n, 4'b1110);
    chk("rst_bcd", bcd_out, 4'h0);
    chk("rst_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("scan_d1", anode_n, 4'b1101);
    repeat (4) @(negedge clk);
    chk("scan_d2", anode_n, 4'b1011);
    repeat (4) @(negedge clk);
    chk("scan_d3", anode_n, 4'b0111);
    repeat (4) @(negedge clk);
    chk("scan_wrap", anode_n, 4'b1110);
    repeat (16) @(negedge clk);

    do_load(1234);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", cnt, 15);
    scan_read(dig);
    chk("dig_1234", dig, 16'h1234);
    chk("ovf_1234", overflow, 1'b0);

    do_load(12345);
    wait_idle();
    scan_read(dig);
    chk("dig_sat", dig, 16'h9999);
    chk("ovf_sat", overflow, 1'b1);
    do_load(42);
    wait_idle();
    scan_read(dig);
    chk("dig_42", dig, 16'h0042);
    chk("ovf_42", overflow, 1'b0);

    blank_lz = 1'b1;
    do_load(7);
    wait_idle();
    scan_read(dig);
    chk("blank_7", dig, 16'hFFF7);
    do_load(0);
    wait_idle();
    scan_read(dig);
    chk("blank_0", dig, 16'hFFF0);
    do_load(1005);
    wait_idle();
    scan_read(dig);
    chk("blank_1005", dig, 16'h1005);
    blank_lz = 1'b0;

    do_load(1234);
    repeat (2) @(negedge clk);
    load   = 1'b1;
    bin_in = W'(5678);
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_commit", busy, 1'b1);
    @(negedge clk);
    chk("busy_fell", busy, 1'b0);
    do_load(5678);
    chk("accept_after", busy, 1'b1);
    wait_idle();
    scan_read(dig);
    chk("dig_5678", dig, 16'h5678);

    do_load(9999);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_anode", anode_n, 4'b1110);
    chk("abort_bcd", bcd_out, 4'h0);
    chk("abort_ovf", overflow, 1'b0);
    scan_read(dig);
    chk("abort_disp", dig, 16'h0000);
    do_load(321);
    wait_idle();
    scan_read(dig);
    chk("dig_321", dig, 16'h0321);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
